// File: rtl/ucnt_pkg.sv
// ucnt_pkg: shared constants and helpers for param_universal_counter
package ucnt_pkg;
    localparam logic UCNT_DIR_UP = 1'b1;
    localparam logic UCNT_DIR_DOWN = 1'b0;
    localparam int UCNT_DEFAULT_WIDTH = 8;
    function automatic int ucnt_pw(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction
endpackage

// File: rtl/ucnt_prescaler.sv
// ucnt_prescaler: divides enabled cycles by PRESCALE, tick on the last one
module ucnt_prescaler
    import ucnt_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int PW = ucnt_pw(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] cnt;
    assign tick = en && cnt == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/param_universal_counter.sv
// param_universal_counter: bounded up/down counter with step, prescaler and tc pulse
// Saturation mode and the sat port exist only when UCNT_SAT_EN is defined.
module param_universal_counter
    import ucnt_pkg::*;
#(
    parameter int WIDTH = UCNT_DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_down_count,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] max_value,
`ifdef UCNT_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count_out,
    output logic             tc
);
    logic tick, sat_on, ovf, udf, oor, ev;
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] nxt, ld;
`ifdef UCNT_SAT_EN
    assign sat_on = sat;
`else
    assign sat_on = 1'b0;
`endif
    ucnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk(clk), .rst(rst), .en(en), .clr(load), .tick(tick)
    );
    always_comb begin
        sum = {1'b0, count_out} + {1'b0, step};
        ld = load_value > max_value ? max_value : load_value;
        oor = count_out > max_value;
        ovf = sum > {1'b0, max_value};
        udf = step > count_out;
        ev = 1'b0;
        nxt = count_out;
        // a zero step is never a boundary event, even when out of range
        if (step != '0) begin
            if (up_down_count == UCNT_DIR_UP) begin
                ev = ovf;
                nxt = ovf ? (sat_on ? max_value : '0) : sum[WIDTH-1:0];
            end else begin
                ev = oor || udf;
                nxt = oor ? max_value : udf ? (sat_on ? '0 : max_value) : count_out - step;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out <= '0;
            tc <= 1'b0;
        end else if (load) begin
            count_out <= ld;
            tc <= 1'b0;
        end else if (tick) begin
            count_out <= nxt;
            tc <= ev;
        end else begin
            tc <= 1'b0;
        end
    end
endmodule

// File: tb/tb_param_universal_counter.sv
// tb_param_universal_counter: directed checks on PRESCALE=1 and PRESCALE=4 instances
module tb_param_universal_counter;
    logic clk = 0;
    logic rst, en, load, up_down_count, sat;
    logic [7:0] load_value, step, max_value;
    logic [7:0] c1, c4;
    logic tc1, tc4;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    param_universal_counter #(.WIDTH(8), .PRESCALE(1)) d1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_value(load_value),
        .up_down_count(up_down_count), .step(step), .max_value(max_value),
`ifdef UCNT_SAT_EN
        .sat(sat),
`endif
        .count_out(c1), .tc(tc1)
    );
    param_universal_counter #(.WIDTH(8), .PRESCALE(4)) d4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_value(load_value),
        .up_down_count(up_down_count), .step(step), .max_value(max_value),
`ifdef UCNT_SAT_EN
        .sat(sat),
`endif
        .count_out(c4), .tc(tc4)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tk(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1; en = 0; load = 0; up_down_count = 1; sat = 0;
        load_value = 0; step = 1; max_value = 9;
        #1;
        chk("rst_c1", c1, 0); chk("rst_tc1", tc1, 0); chk("rst_c4", c4, 0);
        tk(2);
        rst = 0; en = 1;
        for (int i = 1; i <= 9; i++) begin
            tk();
            chk("up_c", c1, i); chk("up_tc", tc1, 0);
        end
        tk();
        chk("wrap_c", c1, 0); chk("wrap_tc", tc1, 1);
        tk();
        chk("after_c", c1, 1); chk("after_tc", tc1, 0);

        load = 1; load_value = 5; max_value = 20; step = 3; up_down_count = 0;
        tk();
        chk("ld5", c1, 5);
        load = 0;
        tk(); chk("dn2", c1, 2); chk("dn2_tc", tc1, 0);
        tk(); chk("dn20", c1, 20); chk("dn20_tc", tc1, 1);
        tk(); chk("dn17", c1, 17); chk("dn17_tc", tc1, 0);

        rst = 1; #1;
        chk("rst2_c4", c4, 0);
        rst = 0; up_down_count = 1; step = 1; max_value = 100; en = 1;
        tk(3); chk("ps_e3", c4, 0);
        tk(); chk("ps_e4", c4, 1);
        tk(3); chk("ps_e7", c4, 1);
        tk(); chk("ps_e8", c4, 2);
        tk();
        en = 0;
        tk(2);
        en = 1;
        tk(2); chk("slip_e13", c4, 2);
        tk(); chk("slip_e14", c4, 3); chk("slip_tc", tc4, 0);
        tk(18);
        chk("pre_rst_c4", c4, 7);
        #3 rst = 1;
        #1;
        chk("arst_c4", c4, 0); chk("arst_tc4", tc4, 0);
        rst = 0;
        tk(3); chk("arst_e3", c4, 0);
        tk(); chk("arst_e4", c4, 1);

        load = 1; load_value = 200; max_value = 100; en = 1;
        tk();
        chk("clamp", c1, 100); chk("clamp_tc", tc1, 0); chk("clamp_c4", c4, 100);
        load_value = 50; en = 0;
        tk();
        chk("ld_noen", c1, 50);
        load = 0; en = 1; max_value = 30; up_down_count = 0;
        tk();
        chk("oor_dn", c1, 30); chk("oor_dn_tc", tc1, 1);
        up_down_count = 1;
        tk();
        chk("top_ovf", c1, 0); chk("top_ovf_tc", tc1, 1);
        max_value = 0; step = 2;
        tk();
        chk("max0_c", c1, 0); chk("max0_tc", tc1, 1);
        step = 0;
        tk();
        chk("step0_c", c1, 0); chk("step0_tc", tc1, 0);

`ifdef UCNT_SAT_EN
        sat = 1; max_value = 15; load = 1; load_value = 14; step = 4; up_down_count = 1;
        tk();
        chk("sat_ld", c1, 14);
        load = 0;
        tk(); chk("sat_hi", c1, 15); chk("sat_hi_tc", tc1, 1);
        tk(); chk("sat_hold", c1, 15); chk("sat_hold_tc", tc1, 1);
        up_down_count = 0; step = 20;
        tk(); chk("sat_lo", c1, 0); chk("sat_lo_tc", tc1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
